// File: rtl/if_id_stage_pkg.sv
// -----------------------------------------------------------------------------
// if_id_stage_pkg
// Shared definitions for the fetch-to-decode stage:
//   - datapath widths (instruction, PC, opcode, register, immediate, counter)
//   - instruction field bit positions
//   - decoded field struct and the decode helper
//   - state encoding of the two-entry skid buffer
// -----------------------------------------------------------------------------
package if_id_stage_pkg;

  localparam int INSTR_W = 32;
  localparam int PC_W    = 32;
  localparam int OP_W    = 5;
  localparam int REG_W   = 4;
  localparam int IMM_W   = 15;
  localparam int CNT_W   = 16;

  // Instruction field layout
  localparam int OPC_HI = 31;
  localparam int OPC_LO = 27;
  localparam int RD_HI  = 26;
  localparam int RD_LO  = 23;
  localparam int RS_HI  = 22;
  localparam int RS_LO  = 19;
  localparam int RT_HI  = 18;
  localparam int RT_LO  = 15;
  localparam int IMM_HI = 14;
  localparam int IMM_LO = 0;

  typedef struct packed {
    logic [OP_W-1:0]  opcode;
    logic [REG_W-1:0] rd;
    logic [REG_W-1:0] rs;
    logic [REG_W-1:0] rt;
    logic [IMM_W-1:0] imm;
  } fields_t;

  // Encoding is {main_valid, skid_valid}; 2'b01 is never produced.
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b10,
    FULL  = 2'b11
  } sb_state_t;

  // Pure bit slicing; the immediate stays raw, extension happens downstream.
  function automatic fields_t decode_fields(input logic [INSTR_W-1:0] instr);
    fields_t f;
    f.opcode = instr[OPC_HI:OPC_LO];
    f.rd     = instr[RD_HI:RD_LO];
    f.rs     = instr[RS_HI:RS_LO];
    f.rt     = instr[RT_HI:RT_LO];
    f.imm    = instr[IMM_HI:IMM_LO];
    return f;
  endfunction

endpackage

// File: rtl/if_id_stage_if.sv
// -----------------------------------------------------------------------------
// if_id_stage_if
// Bundles the upstream fetch handshake, the flush request and the decoded
// downstream handshake of the fetch-to-decode stage.
//   slave  : the stage itself (receives fetch beats, produces decoded beats)
//   master : the environment (fetch unit + decode consumer)
// Signals:
//   in_valid/in_ready/in_instr/in_pc   upstream beat
//   flush                              discard all buffered beats
//   out_valid/out_ready                downstream beat handshake
//   out_pc/out_opcode/out_rd/out_rs/out_rt/out_imm   decoded fields
//   out_stall_cnt                      saturating back-pressure cycle count
// -----------------------------------------------------------------------------
interface if_id_stage_if;
  import if_id_stage_pkg::*;

  logic               in_valid;
  logic               in_ready;
  logic [INSTR_W-1:0] in_instr;
  logic [PC_W-1:0]    in_pc;
  logic               flush;
  logic               out_valid;
  logic               out_ready;
  logic [PC_W-1:0]    out_pc;
  logic [OP_W-1:0]    out_opcode;
  logic [REG_W-1:0]   out_rd;
  logic [REG_W-1:0]   out_rs;
  logic [REG_W-1:0]   out_rt;
  logic [IMM_W-1:0]   out_imm;
  logic [CNT_W-1:0]   out_stall_cnt;

  modport slave (
    input  in_valid, in_instr, in_pc, flush, out_ready,
    output in_ready, out_valid, out_pc, out_opcode, out_rd, out_rs, out_rt,
           out_imm, out_stall_cnt
  );

  modport master (
    output in_valid, in_instr, in_pc, flush, out_ready,
    input  in_ready, out_valid, out_pc, out_opcode, out_rd, out_rs, out_rt,
           out_imm, out_stall_cnt
  );

endinterface

// File: rtl/if_id_stage_skid.sv
// -----------------------------------------------------------------------------
// skid_buffer
// Generic two-entry valid/ready buffer: a main register that drives the
// output and a one-entry skid register that absorbs the beat arriving in the
// cycle the consumer stalls. in_ready is registered so the upstream ready
// path does not depend combinationally on out_ready.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   flush           drop both entries, return to EMPTY
//   in_valid/in_ready/in_data      upstream beat
//   out_valid/out_ready/out_data   downstream beat (out_data = main register)
// -----------------------------------------------------------------------------
module skid_buffer
  import if_id_stage_pkg::*;
#(
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data
);

  sb_state_t         state;
  logic [DATA_W-1:0] main_p0;
  logic [DATA_W-1:0] skid_p0;
  logic              accept;
  logic              drain;

  assign out_valid = state[1];
  assign out_data  = main_p0;
  assign accept    = in_valid && in_ready;
  assign drain     = out_valid && out_ready;

  // ---- buffer stage: state, registered in_ready, main/skid entries ----
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= EMPTY;
      in_ready <= 1'b1;
      main_p0  <= '0;
      skid_p0  <= '0;
    end else if (flush) begin
      // Any beat accepted this cycle is discarded; a concurrent drain has
      // already been seen downstream because out_valid was high.
      state    <= EMPTY;
      in_ready <= 1'b1;
    end else begin
      unique case (state)
        EMPTY: begin
          if (accept) begin
            main_p0 <= in_data;
            state   <= ONE;
          end
        end
        ONE: begin
          if (accept && drain) begin
            main_p0 <= in_data;
          end else if (accept) begin
            skid_p0  <= in_data;
            state    <= FULL;
            in_ready <= 1'b0;
          end else if (drain) begin
            state <= EMPTY;
          end
        end
        FULL: begin
          // in_ready is low here, so no accept can coincide with the drain.
          if (drain) begin
            main_p0  <= skid_p0;
            state    <= ONE;
            in_ready <= 1'b1;
          end
        end
        default: begin
          state    <= EMPTY;
          in_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: rtl/if_id_stage.sv
// -----------------------------------------------------------------------------
// if_id_stage
// Fetch-to-decode pipeline stage. Buffers {pc, instr} beats in a skid
// buffer, slices the presented instruction into opcode / rd / rs / rt / raw
// immediate, and counts cycles where a decoded beat is held back by the
// consumer (saturating, cleared only by reset).
// Ports:
//   clk   clock, all state on the rising edge
//   rst   synchronous active-high reset
//   bus   if_id_stage_if.slave: upstream beat, flush, decoded outputs and
//         stall counter
// -----------------------------------------------------------------------------
module if_id_stage
  import if_id_stage_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  if_id_stage_if.slave   bus
);

  localparam int BEAT_W = PC_W + INSTR_W;

  logic [BEAT_W-1:0]  in_beat;
  logic [BEAT_W-1:0]  beat_p0;
  logic               vld_p0;
  logic [INSTR_W-1:0] instr_p0;
  fields_t            fields_p0;
  logic [CNT_W-1:0]   stall_cnt;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign in_beat = {bus.in_pc, bus.in_instr};

  skid_buffer #(
    .DATA_W (BEAT_W)
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .flush     (bus.flush),
    .in_valid  (bus.in_valid),
    .in_ready  (bus.in_ready),
    .in_data   (in_beat),
    .out_valid (vld_p0),
    .out_ready (bus.out_ready),
    .out_data  (beat_p0)
  );

  // ---- decode stage: combinational field slicing of the main entry ----
  // Fields come straight from the main register, so they hold their value
  // while stalled and after the beat drains.
  assign instr_p0  = beat_p0[INSTR_W-1:0];
  assign fields_p0 = decode_fields(instr_p0);

  assign bus.out_valid  = vld_p0;
  assign bus.out_pc     = beat_p0[BEAT_W-1:INSTR_W];
  assign bus.out_opcode = fields_p0.opcode;
  assign bus.out_rd     = fields_p0.rd;
  assign bus.out_rs     = fields_p0.rs;
  assign bus.out_rt     = fields_p0.rt;
  assign bus.out_imm    = fields_p0.imm;

  // ---- stall counter: back-pressured valid cycles, survives flush ----
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (vld_p0 && !bus.out_ready) begin
      stall_cnt <= sat_inc(stall_cnt);
    end
  end

  assign bus.out_stall_cnt = stall_cnt;

endmodule

// File: tb/tb_if_id_stage.sv
module tb_if_id_stage;
  import if_id_stage_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  if_id_stage_if bus ();

  if_id_stage dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic beat(input logic [31:0] pc, input logic [31:0] instr);
    bus.in_valid = 1'b1;
    bus.in_pc    = pc;
    bus.in_instr = instr;
  endtask

  initial begin
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_instr  = '0;
    bus.in_pc     = '0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b0;
    tick();
    tick();

    // Reset state
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_in_ready",  32'(bus.in_ready),  32'd1);
    chk("rst_out_pc",    bus.out_pc,         32'd0);
    chk("rst_opcode",    32'(bus.out_opcode), 32'd0);
    chk("rst_imm",       32'(bus.out_imm),   32'd0);
    chk("rst_stall",     32'(bus.out_stall_cnt), 32'd0);

    // Single beat, field slicing
    rst = 1'b0;
    bus.out_ready = 1'b1;
    beat(32'h100, 32'h2A8C7FFF);
    tick();
    bus.in_valid = 1'b0;
    chk("t1_valid",  32'(bus.out_valid),  32'd1);
    chk("t1_opcode", 32'(bus.out_opcode), 32'd5);
    chk("t1_rd",     32'(bus.out_rd),     32'd5);
    chk("t1_rs",     32'(bus.out_rs),     32'd1);
    chk("t1_rt",     32'(bus.out_rt),     32'd8);
    chk("t1_imm",    32'(bus.out_imm),    32'h7FFF);
    chk("t1_pc",     bus.out_pc,          32'h100);
    tick();
    chk("t1_drained",     32'(bus.out_valid),  32'd0);
    chk("t1_fields_hold", 32'(bus.out_opcode), 32'd5);

    // Streaming at full throughput
    for (int i = 0; i < 4; i++) begin
      beat(32'(4 * i), (32'(i + 1) << 27) | 32'(i));
      tick();
      chk("t2_in_ready", 32'(bus.in_ready),   32'd1);
      chk("t2_valid",    32'(bus.out_valid),  32'd1);
      chk("t2_pc",       bus.out_pc,          32'(4 * i));
      chk("t2_opcode",   32'(bus.out_opcode), 32'(i + 1));
      chk("t2_imm",      32'(bus.out_imm),    32'(i));
    end
    bus.in_valid = 1'b0;
    tick();
    chk("t2_empty", 32'(bus.out_valid), 32'd0);
    chk("t2_stall", 32'(bus.out_stall_cnt), 32'd0);

    // Back-pressure: fill main + skid, third beat waits
    bus.out_ready = 1'b0;
    beat(32'h10, 32'h10);
    tick();
    chk("t3_one_pc",    bus.out_pc,         32'h10);
    chk("t3_one_ready", 32'(bus.in_ready),  32'd1);
    chk("t3_stall0",    32'(bus.out_stall_cnt), 32'd0);
    beat(32'h14, 32'h14);
    tick();
    chk("t3_full_ready", 32'(bus.in_ready), 32'd0);
    chk("t3_full_pc",    bus.out_pc,        32'h10);
    chk("t3_stall1",     32'(bus.out_stall_cnt), 32'd1);
    beat(32'h18, 32'h18);
    tick();
    chk("t3_hold_pc",    bus.out_pc,        32'h10);
    chk("t3_hold_ready", 32'(bus.in_ready), 32'd0);
    tick();
    chk("t3_stall3", 32'(bus.out_stall_cnt), 32'd3);
    bus.out_ready = 1'b1;
    tick();
    chk("t3_skid_pc",  bus.out_pc,        32'h14);
    chk("t3_ready_up", 32'(bus.in_ready), 32'd1);
    tick();
    bus.in_valid = 1'b0;
    chk("t3_third_pc", bus.out_pc,         32'h18);
    chk("t3_third_vld", 32'(bus.out_valid), 32'd1);
    tick();
    chk("t3_empty", 32'(bus.out_valid), 32'd0);
    chk("t3_stall_final", 32'(bus.out_stall_cnt), 32'd3);

    // Flush in FULL with a beat offered
    bus.out_ready = 1'b0;
    beat(32'h20, 32'h20);
    tick();
    beat(32'h24, 32'h24);
    tick();
    chk("t4_full", 32'(bus.in_ready), 32'd0);
    chk("t4_stall_pre", 32'(bus.out_stall_cnt), 32'd4);
    beat(32'h28, 32'h28);
    bus.flush     = 1'b1;
    bus.out_ready = 1'b1;
    tick();
    bus.flush    = 1'b0;
    bus.in_valid = 1'b0;
    chk("t4_flush_valid", 32'(bus.out_valid), 32'd0);
    chk("t4_flush_ready", 32'(bus.in_ready),  32'd1);
    chk("t4_flush_stall", 32'(bus.out_stall_cnt), 32'd4);
    tick();
    chk("t4_no_ghost", 32'(bus.out_valid), 32'd0);

    // Flush in ONE while a beat is actually accepted: it must be discarded
    bus.out_ready = 1'b0;
    beat(32'h30, 32'h30);
    tick();
    chk("t4b_one_pc", bus.out_pc, 32'h30);
    beat(32'h34, 32'h34);
    bus.flush     = 1'b1;
    bus.out_ready = 1'b1;
    tick();
    bus.flush    = 1'b0;
    bus.in_valid = 1'b0;
    chk("t4b_discard", 32'(bus.out_valid), 32'd0);
    tick();
    chk("t4b_no_ghost", 32'(bus.out_valid), 32'd0);
    chk("t4b_stall", 32'(bus.out_stall_cnt), 32'd4);

    // Reset mid-stream while FULL
    bus.out_ready = 1'b0;
    beat(32'h40, 32'h40);
    tick();
    beat(32'h44, 32'h44);
    tick();
    bus.in_valid = 1'b0;
    chk("t5_full", 32'(bus.in_ready), 32'd0);
    chk("t5_stall_pre", 32'(bus.out_stall_cnt), 32'd5);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t5_rst_valid", 32'(bus.out_valid), 32'd0);
    chk("t5_rst_ready", 32'(bus.in_ready),  32'd1);
    chk("t5_rst_pc",    bus.out_pc,         32'd0);
    chk("t5_rst_opc",   32'(bus.out_opcode), 32'd0);
    chk("t5_rst_stall", 32'(bus.out_stall_cnt), 32'd0);
    bus.out_ready = 1'b1;
    beat(32'h50, 32'h8C2A0123);
    tick();
    bus.in_valid = 1'b0;
    chk("t5_post_valid", 32'(bus.out_valid), 32'd1);
    chk("t5_post_pc",    bus.out_pc,         32'h50);
    chk("t5_post_opc",   32'(bus.out_opcode), 32'h11);
    chk("t5_post_rd",    32'(bus.out_rd),    32'd8);
    chk("t5_post_rs",    32'(bus.out_rs),    32'd5);
    chk("t5_post_rt",    32'(bus.out_rt),    32'd4);
    chk("t5_post_imm",   32'(bus.out_imm),   32'h123);
    tick();

    // Stall counter saturation
    bus.out_ready = 1'b0;
    beat(32'h60, 32'h60);
    tick();
    bus.in_valid = 1'b0;
    repeat (65534) tick();
    chk("t6_near_sat", 32'(bus.out_stall_cnt), 32'hFFFE);
    repeat (3) tick();
    chk("t6_sat",      32'(bus.out_stall_cnt), 32'hFFFF);
    chk("t6_hold_pc",  bus.out_pc,             32'h60);
    chk("t6_hold_vld", 32'(bus.out_valid),     32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/if_id_stage.md
Name: if_id_stage

Overview:
Fetch-to-decode pipeline stage of the 32-bit processor. It accepts fetched instruction/PC beats over a valid/ready handshake and buffers them in a main register plus a one-entry skid register. It splits each instruction into opcode, register, and 15-bit immediate fields. The immediate output feeds the sign-extension stage directly, and the other fields feed register-file read and control decode.

Parameters:
INSTR_W, 32, instruction width
PC_W, 32, program counter width
OP_W, 5, opcode field width
REG_W, 4, register specifier width (16 registers)
IMM_W, 15, immediate field width
CNT_W, 16, stall counter width

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous, active-high reset
in_valid  input  1  upstream beat valid
in_ready  output  1  stage can accept a beat this cycle
in_instr  input  INSTR_W  fetched instruction
in_pc  input  PC_W  PC of fetched instruction
flush  input  1  discard all buffered beats (branch taken/redirect)
out_valid  output  1  decoded beat valid
out_ready  input  1  downstream accepts the beat
out_pc  output  PC_W  PC of the presented beat
out_opcode  output  OP_W  instr[31:27]
out_rd  output  REG_W  instr[26:23]
out_rs  output  REG_W  instr[22:19]
out_rt  output  REG_W  instr[18:15]
out_imm  output  IMM_W  instr[14:0], raw; extension happens downstream
out_stall_cnt  output  CNT_W  count of cycles with out_valid=1 and out_ready=0, saturating

Behaviour:
- Clock and reset: single clock clk. Reset rst is synchronous and active-high.
- Reset values: main_valid=0, skid_valid=0, out_valid=0, in_ready=1, all data/field outputs 0, out_stall_cnt=0.
- State (implicit FSM on {main_valid, skid_valid}):
  - EMPTY = 00
  - ONE = 10
  - FULL = 11
  - 01 is illegal and must never occur.
- in_ready is a registered signal equal to !skid_valid of the current state. It is high in EMPTY and ONE, low in FULL.
- Accept when in_valid && in_ready. Drain when out_valid && out_ready.
- Transitions (no flush):
  - EMPTY, accept -> ONE. The beat loads into main.
  - ONE, accept and drain -> ONE. The new beat replaces main.
  - ONE, accept and no drain -> FULL. The beat loads into skid; in_ready drops next cycle.
  - ONE, drain only -> EMPTY.
  - FULL, drain -> ONE. Skid moves to main; in_ready rises next cycle.
  - FULL, no drain -> FULL. Main and skid are held stable.
- Latency: 1 cycle from accept to out_valid when the stage is empty. Throughput is 1 beat/cycle with out_ready held high.
- Ordering: strict FIFO. No beat is dropped or duplicated except by flush.
- out_valid = main_valid. The field outputs are combinational slices of the main register. Fields hold their last value when out_valid=0.
- flush: synchronous. Next state is EMPTY and in_ready=1.
  - A beat accepted in the same cycle as flush is discarded.
  - A drain in the flush cycle still completes downstream, since out_valid was already high.
- rst has priority over flush. flush has priority over accept and drain state updates.
- out_stall_cnt: increments when out_valid && !out_ready and saturates at all-ones. It clears only on rst, not on flush.
- Data outputs are stable while out_valid && !out_ready (AXI-style hold rule).

Decomposition:
- Shared package holds:
  - instruction field constants: OPC_HI=31, OPC_LO=27, RD_HI=26, RD_LO=23, RS_HI=22, RS_LO=19, RT_HI=18, RT_LO=15, IMM_HI=14, IMM_LO=0
  - widths INSTR_W, PC_W, REG_W, IMM_W
  - typedef for decoded fields {opcode, rd, rs, rt, imm}
- One sub-module is natural: skid_buffer, a generic width-parameterised 2-entry valid/ready buffer with flush. if_id_stage instantiates it on {pc, instr} and adds field slicing and the stall counter.

Test Plan:
- Reset, then in_instr=0x2A8C7FFF, in_pc=0x100, out_ready=1 -> one cycle later out_valid=1, opcode=5, rd=5, rs=1, rt=8, imm=0x7FFF, out_pc=0x100.
- Stream PCs 0x0,0x4,0x8,0xC with out_ready=1 and in_valid=1 every cycle -> in_ready stays 1; outputs appear in order with 1-cycle latency and no bubbles.
- Hold out_ready=0 and offer 3 beats (0x10,0x14,0x18) -> first two are accepted; in_ready=0 from the cycle after the second accept; 0x18 waits. Raise out_ready -> outputs 0x10,0x14,0x18 in order. out_stall_cnt equals the number of stalled valid cycles.
- FULL state, assert flush together with in_valid=1 -> next cycle out_valid=0, in_ready=1; the flushed beat never appears; out_stall_cnt is unchanged.
- Assert rst mid-stream while FULL -> next cycle all outputs are at reset values and out_stall_cnt=0; the first post-reset beat is output correctly.
- Force the stall counter near saturation (0xFFFE) and stall 3 cycles -> count reads 0xFFFF and holds.
